// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: program load, control from hazard/branch logic, and the
// address/instruction pair handed to the IF/ID register.
interface instr_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 32
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [INST_W-1:0] load_data;
  logic              start;
  logic              stall;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] pc_out;
  logic [INST_W-1:0] inst_out;
  logic              fetch_valid;
  logic              halted;
  logic [15:0]       fetch_count;

  modport master (
    output load_en, load_addr, load_data, start, stall, br_taken, br_target,
    input  pc_out, inst_out, fetch_valid, halted, fetch_count
  );

  modport slave (
    input  load_en, load_addr, load_data, start, stall, br_taken, br_target,
    output pc_out, inst_out, fetch_valid, halted, fetch_count
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, loadable instruction memory with zero-latency
// read, stall/branch/halt control and a saturating advancing-fetch counter.
module instr_fetch #(
  parameter int         ADDR_W  = 8,
  parameter int         INST_W  = 32,
  parameter int         DEPTH   = 256,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       fetch_count_q;
  logic [INST_W-1:0] mem_q [DEPTH];

  logic [INST_W-1:0] inst_rd;
  logic              is_halt_op;
  logic [15:0]       fetch_count_d;
  logic              load_ok;

  assign inst_rd       = mem_q[pc_q];
  assign is_halt_op    = (inst_rd[INST_W-1 -: 4] == HALT_OP);
  assign fetch_count_d = (fetch_count_q == 16'hFFFF) ? fetch_count_q
                                                     : fetch_count_q + 16'd1;
  assign load_ok       = bus.load_en && (state_q != RUN);

  // NOTE: the instruction store has no reset; program contents must survive rst,
  // and a reset port on a large array would prevent mapping it onto RAM.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem_q[bus.load_addr] <= bus.load_data;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; blocking assigns would make the result order-dependent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      fetch_count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE, HALT: begin
          if (bus.start) begin
            state_q       <= RUN;
            pc_q          <= '0;
            fetch_count_q <= '0;
          end
        end
        RUN: begin
          // A redirect beats stall and halt; stall in turn masks halt detection.
          if (bus.br_taken) begin
            pc_q          <= bus.br_target;
            fetch_count_q <= fetch_count_d;
          end else if (bus.stall) begin
            pc_q          <= pc_q;
          end else if (is_halt_op) begin
            state_q       <= HALT;
            fetch_count_q <= fetch_count_d;
          end else begin
            pc_q          <= pc_q + ADDR_W'(1);
            fetch_count_q <= fetch_count_d;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode the registered state only, so async reset shows at once.
  assign bus.pc_out      = (state_q == IDLE) ? '0 : pc_q;
  assign bus.inst_out    = (state_q == RUN) ? inst_rd : '0;
  assign bus.fetch_valid = (state_q == RUN);
  assign bus.halted      = (state_q == HALT);
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the fetch stage.
module tb_instr_fetch;

  localparam logic [3:0] HALT_NIB = 4'hF;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk;
  logic rst;

  instr_fetch_if #(.ADDR_W(8), .INST_W(32)) bus ();

  instr_fetch #(
    .ADDR_W (8),
    .INST_W (32),
    .DEPTH  (256),
    .HALT_OP(4'hF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Behavioural model: program memory, mode, PC and fetch counter.
  logic [31:0] m_mem [256];
  int          m_mode;
  int          m_pc;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] nonhalt_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:28] == HALT_NIB) w[31:28] = 4'h1;
    return w;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_pc   = 0;
    m_cnt  = 0;
  endtask

  function automatic int sat_inc(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  task automatic model_step();
    logic [31:0] cur;
    cur = m_mem[m_pc];
    if (m_mode != M_RUN) begin
      if (bus.load_en) m_mem[int'(bus.load_addr)] = bus.load_data;
      if (bus.start) begin
        m_mode = M_RUN;
        m_pc   = 0;
        m_cnt  = 0;
      end
    end else if (bus.br_taken) begin
      m_pc  = int'(bus.br_target);
      m_cnt = sat_inc(m_cnt);
    end else if (bus.stall) begin
      // PC and count hold
    end else if (cur[31:28] == HALT_NIB) begin
      m_mode = M_HALT;
      m_cnt  = sat_inc(m_cnt);
    end else begin
      m_pc  = (m_pc + 1) % 256;
      m_cnt = sat_inc(m_cnt);
    end
  endtask

  task automatic check_outputs();
    check("pc_out",      32'(bus.pc_out),      (m_mode == M_IDLE) ? 32'd0 : 32'(m_pc));
    check("inst_out",    bus.inst_out,         (m_mode == M_RUN) ? m_mem[m_pc] : 32'd0);
    check("fetch_valid", 32'(bus.fetch_valid), 32'(m_mode == M_RUN));
    check("halted",      32'(bus.halted),      32'(m_mode == M_HALT));
    check("fetch_count", 32'(bus.fetch_count), 32'(m_cnt));
  endtask

  // One clock: check outputs mid-cycle, advance the model on the edge,
  // then drop single-cycle pulses.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
    bus.load_en  = 1'b0;
    bus.start    = 1'b0;
    bus.br_taken = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    tick();
  endtask

  task automatic branch_to(input logic [7:0] t);
    bus.br_taken  = 1'b1;
    bus.br_target = t;
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.start = 1'b0; bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc",    32'(bus.pc_out), 32'd0);
    check("rst_inst",  bus.inst_out, 32'd0);
    check("rst_valid", 32'(bus.fetch_valid), 32'd0);
    check("rst_halt",  32'(bus.halted), 32'd0);
    check("rst_cnt",   32'(bus.fetch_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Program image: random non-halt filler plus directed words
    for (int a = 0; a < 256; a++) load_word(8'(a), nonhalt_word());
    for (int a = 0; a < 4; a++) load_word(8'(a), 32'h1000_0001 + 32'(a));
    load_word(8'h04, 32'hF000_0000);
    load_word(8'h40, 32'hABCD_0040);
    load_word(8'hFF, 32'h1234_5678);
    load_word(8'h12, 32'hF000_0012);

    // Sequential fetch to halt
    bus.start = 1'b1;
    tick();
    check("seq_pc0", 32'(bus.pc_out), 32'd0);
    check("seq_inst0", bus.inst_out, 32'h1000_0001);
    repeat (5) tick();
    check("seq_halted", 32'(bus.halted), 32'd1);
    check("seq_halt_pc", 32'(bus.pc_out), 32'd4);
    check("seq_halt_valid", 32'(bus.fetch_valid), 32'd0);
    check("seq_cnt", 32'(bus.fetch_count), 32'd5);

    // Stall two cycles at pc=2
    bus.start = 1'b1;
    tick();
    repeat (2) tick();
    check("stall_pc_pre", 32'(bus.pc_out), 32'd2);
    bus.stall = 1'b1;
    repeat (2) tick();
    bus.stall = 1'b0;
    check("stall_pc_hold", 32'(bus.pc_out), 32'd2);
    check("stall_cnt_hold", 32'(bus.fetch_count), 32'd2);
    tick();
    check("stall_pc_next", 32'(bus.pc_out), 32'd3);
    check("stall_cnt_next", 32'(bus.fetch_count), 32'd3);

    // Branch overrides stall
    branch_to(8'h01);
    bus.stall = 1'b1;
    branch_to(8'h40);
    bus.stall = 1'b0;
    check("br_pc", 32'(bus.pc_out), 32'h40);
    check("br_inst", bus.inst_out, 32'hABCD_0040);

    // Wrap-around at 8'hFF
    branch_to(8'hFF);
    check("wrap_inst", bus.inst_out, 32'h1234_5678);
    tick();
    check("wrap_pc", 32'(bus.pc_out), 32'd0);
    check("wrap_valid", 32'(bus.fetch_valid), 32'd1);

    // Stall masks halt detection until released
    repeat (4) tick();
    bus.stall = 1'b1;
    repeat (2) tick();
    check("hsup_halted", 32'(bus.halted), 32'd0);
    check("hsup_valid", 32'(bus.fetch_valid), 32'd1);
    bus.stall = 1'b0;
    tick();
    check("hsup_release", 32'(bus.halted), 32'd1);
    check("hsup_pc", 32'(bus.pc_out), 32'd4);

    // Branch on the halt cycle cancels the halt
    bus.start = 1'b1;
    tick();
    repeat (4) tick();
    branch_to(8'h10);
    check("hbr_halted", 32'(bus.halted), 32'd0);
    check("hbr_pc", 32'(bus.pc_out), 32'h10);
    repeat (3) tick();
    check("hbr_late_halt", 32'(bus.halted), 32'd1);
    check("hbr_late_pc", 32'(bus.pc_out), 32'h12);

    // Load and start together from HALT
    bus.load_en   = 1'b1;
    bus.load_addr = 8'h00;
    bus.load_data = 32'h0BAD_F00D;
    bus.start     = 1'b1;
    tick();
    check("ldst_pc", 32'(bus.pc_out), 32'd0);
    check("ldst_inst", bus.inst_out, 32'h0BAD_F00D);

    // Asynchronous reset mid-RUN
    repeat (2) tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_pc", 32'(bus.pc_out), 32'd0);
    check("arst_inst", bus.inst_out, 32'd0);
    check("arst_valid", 32'(bus.fetch_valid), 32'd0);
    check("arst_halt", 32'(bus.halted), 32'd0);
    check("arst_cnt", 32'(bus.fetch_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(7) == 0) w[31:28] = HALT_NIB;
      else if (w[31:28] == HALT_NIB) w[31:28] = 4'h2;
      bus.load_en   = ($urandom_range(2) == 0);
      bus.load_addr = 8'($urandom);
      bus.load_data = w;
      bus.start     = ($urandom_range(5) == 0);
      bus.stall     = ($urandom_range(3) == 0);
      bus.br_taken  = ($urandom_range(7) == 0);
      bus.br_target = 8'($urandom);
      tick();
    end
    bus.stall = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the pipelined datapath. Holds the 8-bit program counter and a loadable instruction memory, and presents one address/instruction pair per cycle to the IF/ID pipeline register, which captures `pc_out` and `inst_out` on the same rising edge. Supports stall from hazard logic, branch redirect from a later stage, program loading while idle, and halt on a dedicated opcode.

## Interface

Parameters:
- `ADDR_W`, default 8: PC and memory address width.
- `INST_W`, default 32: instruction width.
- `DEPTH`, default 256: instruction memory words. Must equal 2^ADDR_W.
- `HALT_OP`, default 4'hF: value of `inst[31:28]` that halts fetch.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: **asynchronous, active-high reset**.
- `load_en`, in, 1: write `load_data` to `mem[load_addr]`. Honoured only in IDLE or HALT.
- `load_addr`, in, ADDR_W: load write address.
- `load_data`, in, INST_W: load write data.
- `start`, in, 1: begin fetching at address 0. Honoured only in IDLE or HALT.
- `stall`, in, 1: hold the PC for this cycle.
- `br_taken`, in, 1: redirect the PC to `br_target`.
- `br_target`, in, ADDR_W: redirect address.
- `pc_out`, out, ADDR_W: address of the current fetch. Feeds IF/ID `addIn`.
- `inst_out`, out, INST_W: instruction at `pc_out`. Feeds IF/ID `instIn`.
- `fetch_valid`, out, 1: `inst_out` is a real fetch, not a bubble.
- `halted`, out, 1: state is HALT.
- `fetch_count`, out, 16: number of advancing fetches since `start`. Saturates at 16'hFFFF.

## Operation

FSM states are IDLE, RUN and HALT.

- **Reset:**
  - Forces IDLE, `pc`=0 and `fetch_count`=0.
  - Memory contents are not cleared.
- **IDLE:**
  - Outputs are `pc_out`=0, `inst_out`=0, `fetch_valid`=0, `halted`=0.
  - `load_en` writes memory.
  - `start` moves to RUN with `pc`=0 and `fetch_count`=0.
- **RUN:**
  - `pc_out`=`pc`.
  - `inst_out`=`mem[pc]`, a combinational read of the registered PC.
  - `fetch_valid`=1.
  - `load_en` and `start` are ignored.
- **PC update in RUN, in priority order at each edge:**
  1. `br_taken` sets `pc`=`br_target`. It overrides `stall` and halt detection.
  2. `stall` holds `pc` and `fetch_count`, and suppresses halt detection.
  3. `inst_out[31:28]`==`HALT_OP` moves to HALT. `pc` holds at the halt instruction address and `fetch_count` increments.
  4. Otherwise `pc`=`pc`+1 modulo 2^ADDR_W, so 8'hFF wraps to 8'h00, and `fetch_count` increments.
- **`fetch_count`:**
  - Increments on cases 3 and 4.
  - Also increments on case 1, since a redirect counts as an advancing fetch.
  - Holds at 16'hFFFF once reached.
- **HALT:**
  - `pc_out`=halt address, `inst_out`=0, `fetch_valid`=0, `halted`=1.
  - `fetch_count` holds.
  - `load_en` writes memory.
  - `start` restarts as from IDLE: `pc`=0 and `fetch_count`=0.
- **Simultaneous `load_en` and `start` in IDLE/HALT:** the write is committed at that edge, and the first RUN fetch reads the updated memory.
- **Reset mid-RUN:** returns to IDLE immediately, with outputs at their IDLE values without waiting for a clock edge.

## Timing

- All state updates occur on the rising edge of `clk`. `rst` acts asynchronously.
- **Start:** `start` sampled at edge k gives `pc_out`=0 and `fetch_valid`=1 from after edge k.
- **Address to instruction:** zero-cycle latency. `inst_out` is valid in the same cycle `pc_out` changes, so IF/ID captures a consistent pair.
- **Branch:** `br_taken` sampled at edge k makes `pc_out`=`br_target` after edge k. Discarding wrong-path instructions already in IF/ID is the downstream flush logic's job.
- **Stall:** each stalled cycle repeats the same `pc_out`/`inst_out`.
- **Halt:** a HALT instruction presented in cycle n gives `halted`=1 after the edge ending cycle n. The halt instruction itself is delivered once with `fetch_valid`=1.
- **Writes:** memory writes land at the edge and are visible to reads in the following cycle.

## Test plan

- **Reset:** assert `rst` mid-cycle during RUN → `pc_out`=0, `inst_out`=0, `fetch_valid`=0 and `halted`=0 immediately; `fetch_count`=0.
- **Sequential fetch:** load mem[0..3]=32'h10000001..32'h10000004 and mem[4]=32'hF0000000, then pulse `start` → `pc_out` 0,1,2,3,4 with matching `inst_out`; then `halted`=1, `pc_out`=4, `fetch_valid`=0, `fetch_count`=5.
- **Stall:** assert `stall` for 2 cycles at `pc`=2 → `pc_out`=2 for 3 cycles, then 3; `fetch_count` does not advance while stalled.
- **Branch priority:** at `pc`=1, assert `br_taken`=1 with `br_target`=8'h40 together with `stall`=1 → next `pc_out`=8'h40 and `inst_out`=mem[64].
- **Wrap-around:** branch to 8'hFF where mem[255] is not HALT → next `pc_out`=8'h00.
- **Halt suppression:** stall while a HALT instruction is presented → remains in RUN until the cycle `stall` deasserts. A branch on the HALT cycle → no halt and `pc_out`=target. Then load_en + start in HALT → restart at 0 with the new mem[0].
